// File: rtl/fetch_pair_queue_pkg.sv
// Shared types and sizing helpers for the dual-issue fetch queue.
// The entry struct is sized by FQ_XLEN; the top's XLEN parameter must match it.
package fetch_pair_queue_pkg;

  localparam int FQ_DEPTH_DEFAULT = 8;
  localparam int FQ_XLEN          = 32;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
    logic               hit;
    logic               pred;
  } fq_entry_t;

  function automatic int fq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fq_entry_ram.sv
// Entry storage: two write ports at consecutive (wrapping) addresses, and two
// asynchronous read ports at raddr and raddr+1.
module fq_entry_ram
  import fetch_pair_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int PTR_W = fq_ptr_w(FQ_DEPTH_DEFAULT)
) (
  input  logic             clk,
  input  logic             i_we1,
  input  logic             i_we2,
  input  logic [PTR_W-1:0] i_waddr,
  input  fq_entry_t        i_wdata1,
  input  fq_entry_t        i_wdata2,
  input  logic [PTR_W-1:0] i_raddr,
  output fq_entry_t        o_rdata1,
  output fq_entry_t        o_rdata2
);

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] w_waddr2;
  logic [PTR_W-1:0] w_raddr2;

  // DEPTH is a power of two, so plain pointer overflow gives the wrap.
  assign w_waddr2 = i_waddr + PTR_W'(1);
  assign w_raddr2 = i_raddr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (i_we1) r_mem[i_waddr]  <= i_wdata1;
    if (i_we2) r_mem[w_waddr2] <= i_wdata2;
  end

  assign o_rdata1 = r_mem[i_raddr];
  assign o_rdata2 = r_mem[w_raddr2];

endmodule

// File: rtl/fetch_pair_queue.sv
// Dual-issue instruction queue between fetch (F1/F2) and decode (D1/D2).
// Optional same-cycle bypass on an empty queue: FETCH_PAIR_QUEUE_BYPASS_EN.
module fetch_pair_queue
  import fetch_pair_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int XLEN  = FQ_XLEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [XLEN-1:0]        in_pc1,
  input  logic [XLEN-1:0]        in_instr1,
  input  logic                   in_hit1,
  input  logic                   in_pred1,
  input  logic [XLEN-1:0]        in_pc2,
  input  logic [XLEN-1:0]        in_instr2,
  input  logic                   in_hit2,
  input  logic                   in_pred2,
  output logic                   in_ready,
  output logic                   out_valid1,
  output logic                   out_valid2,
  output logic [XLEN-1:0]        out_pc1,
  output logic [XLEN-1:0]        out_instr1,
  output logic                   out_hit1,
  output logic                   out_pred1,
  output logic [XLEN-1:0]        out_pc2,
  output logic [XLEN-1:0]        out_instr2,
  output logic                   out_hit2,
  output logic                   out_pred2,
  input  logic [1:0]             deq_cnt,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = fq_ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a pair transfers on any edge where in_valid & in_ready & ~flush;
  // in_ready depends only on registered occupancy. Decode takes the oldest
  // min(deq_cnt, count) entries on every edge, with no separate ready.
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic      w_enq_fire;
  logic [1:0] w_enq_n;
  logic [1:0] w_deq_req;
  logic [1:0] w_deq_eff;
  logic [1:0] w_tail_adv;
  logic [1:0] w_head_adv;
  logic      w_we1;
  logic      w_we2;
  fq_entry_t w_in1;
  fq_entry_t w_in2;
  fq_entry_t w_wdata1;
  fq_entry_t w_wdata2;
  fq_entry_t w_rd1;
  fq_entry_t w_rd2;
  fq_entry_t w_out1;
  fq_entry_t w_out2;
  logic      w_ov1;
  logic      w_ov2;
`ifdef FETCH_PAIR_QUEUE_BYPASS_EN
  logic [1:0] w_byp_deq;
`endif

  assign in_ready   = (r_count <= CNT_W'(DEPTH - 2));
  assign w_enq_fire = in_valid & in_ready & ~flush;
  // A predicted-taken BTB hit on F1 puts F2 on the wrong path.
  assign w_enq_n    = w_enq_fire ? ((in_hit1 & in_pred1) ? 2'd1 : 2'd2) : 2'd0;
  assign w_deq_req  = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
  assign w_deq_eff  = (r_count < CNT_W'(w_deq_req)) ? r_count[1:0] : w_deq_req;

  assign w_in1 = '{pc: in_pc1, instr: in_instr1, hit: in_hit1, pred: in_pred1};
  assign w_in2 = '{pc: in_pc2, instr: in_instr2, hit: in_hit2, pred: in_pred2};

  always_comb begin
    w_we1      = w_enq_fire;
    w_we2      = w_enq_fire && (w_enq_n == 2'd2);
    w_wdata1   = w_in1;
    w_wdata2   = w_in2;
    w_tail_adv = w_enq_n;
    w_head_adv = w_deq_eff;
    w_out1     = w_rd1;
    w_out2     = w_rd2;
    w_ov1      = (r_count != '0);
    w_ov2      = (r_count >= CNT_W'(2));
`ifdef FETCH_PAIR_QUEUE_BYPASS_EN
    w_byp_deq = (w_deq_req < w_enq_n) ? w_deq_req : w_enq_n;
    // Empty queue: present the incoming pair directly, store only the leftovers.
    if (w_enq_fire && (r_count == '0)) begin
      w_out1     = w_in1;
      w_out2     = w_in2;
      w_ov1      = 1'b1;
      w_ov2      = (w_enq_n == 2'd2);
      w_head_adv = 2'd0;
      w_tail_adv = w_enq_n - w_byp_deq;
      w_we1      = (w_tail_adv != 2'd0);
      w_wdata1   = (w_byp_deq == 2'd1) ? w_in2 : w_in1;
      w_we2      = (w_tail_adv == 2'd2);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_head_adv);
      r_tail  <= r_tail + PTR_W'(w_tail_adv);
      r_count <= r_count + CNT_W'(w_tail_adv) - CNT_W'(w_head_adv);
    end
  end

  fq_entry_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk      (clk),
    .i_we1    (w_we1),
    .i_we2    (w_we2),
    .i_waddr  (r_tail),
    .i_wdata1 (w_wdata1),
    .i_wdata2 (w_wdata2),
    .i_raddr  (r_head),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2)
  );

  assign out_valid1 = w_ov1;
  assign out_valid2 = w_ov2;
  assign out_pc1    = w_out1.pc;
  assign out_instr1 = w_out1.instr;
  assign out_hit1   = w_out1.hit;
  assign out_pred1  = w_out1.pred;
  assign out_pc2    = w_out2.pc;
  assign out_instr2 = w_out2.instr;
  assign out_hit2   = w_out2.hit;
  assign out_pred2  = w_out2.pred;
  assign count      = r_count;

endmodule

// File: doc/fetch_pair_queue.md
Name: fetch_pair_queue

Overview:
- Dual-issue instruction queue between fetch (F1/F2 slots) and decode (D1/D2 slots).
- Each fetch cycle it accepts up to two instructions together with their branch-predictor metadata (BTB hit, predicted-taken bit).
- It presents the two oldest entries to decode, which pops 0–2 per cycle.
- Decode branch resolution can flush it; its back-pressure drives the fetch-stage stall.

Parameters:
- DEPTH, 8, number of single-instruction entries; power of two, ≥4.
- XLEN, 32, width of PC and instruction words.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  discard all contents (OR of both decode-slot flush requests)
- in_valid  in  1  fetch pair valid
- in_pc1  in  XLEN  PC of F1 instruction
- in_instr1  in  XLEN  F1 instruction word
- in_hit1  in  1  F1 BTB hit
- in_pred1  in  1  F1 predicted taken
- in_pc2, in_instr2, in_hit2, in_pred2  in  XLEN/XLEN/1/1  same fields for F2
- in_ready  out  1  queue can take a full pair; fetch stall = ~in_ready
- out_valid1, out_valid2  out  1 each  head and head+1 entries valid
- out_pc1, out_instr1, out_hit1, out_pred1  out  XLEN/XLEN/1/1  head entry
- out_pc2, out_instr2, out_hit2, out_pred2  out  XLEN/XLEN/1/1  head+1 entry
- deq_cnt  in  2  entries decode consumes this cycle (0, 1, 2)
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage is a circular buffer.
  - head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked separately.
- Reset:
  - head = tail = count = 0.
  - All out_valid = 0; in_ready = 1.
  - Entry payload is don't-care.
- in_ready = (count ≤ DEPTH-2), registered-state based; not combinationally dependent on deq_cnt.
- Enqueue happens when in_valid & in_ready & ~flush. enq_n is:
  - 1 if in_hit1 & in_pred1: F2 is on the wrong path and is dropped.
  - 2 otherwise.
  - F1 is written at tail, F2 at tail+1.
- Dequeue:
  - deq_eff = min(deq_cnt, count), computed from registered count.
  - Over-request is clamped, never underflows.
  - deq_cnt = 2 with only out_valid1 set pops 1.
- Per edge: count' = count + enq_n − deq_eff; head += deq_eff; tail += enq_n.
  - Simultaneous enqueue and dequeue are both honoured in the same cycle.
- Outputs:
  - out_valid1 = (count ≥ 1); out_valid2 = (count ≥ 2).
  - Payload is read combinationally from head and head+1 (with wrap).
- Latency: an entry written at edge N is visible on the outputs from cycle N+1 (no bypass in base build).
- Ordering: strict program order.
  - F1 is always older than F2.
  - out1 is always older than out2.
- flush:
  - Highest priority below reset.
  - Next state is head = tail = count = 0.
  - That cycle's enqueue and dequeue are ignored.
  - in_ready is 1 the following cycle.
- reset asserted mid-operation: identical to flush; no partial state survives.
- Full boundary:
  - count = DEPTH-1 → in_ready = 0, even if a 1-entry enqueue would fit.
  - count = DEPTH is reachable only via a DEPTH-2 + 2 enqueue.
- Wrap: tail at DEPTH-1 writes F1 to DEPTH-1 and F2 to 0.

Optional Feature:
FETCH_PAIR_QUEUE_BYPASS_EN
- Defined: when count = 0 and the enqueue condition holds, the incoming pair drives the out_* ports in the same cycle.
  - out_valid2 is 0 if F2 is dropped.
  - Only the entries not consumed by deq_eff_bypass = min(deq_cnt, enq_n) are written.
  - This gives zero-cycle fetch-to-decode latency on an empty queue.
- Undefined: base 1-cycle behaviour; no combinational path from in_* to out_*.

Decomposition:
- Package fetch_pair_queue_pkg:
  - fq_entry_t struct: pc, instr, hit, pred.
  - FQ_DEPTH_DEFAULT constant.
  - Pointer-width localparam helper.
- Optional sub-module fq_entry_ram: DEPTH × fq_entry_t, two write ports at consecutive addresses, two asynchronous read ports.
- Control (pointers, count, clamp, flush) stays in the top.

Test Plan:
1. Reset, then push pair pc1=0x100, pc2=0x104 with no prediction → next cycle out_valid1 = out_valid2 = 1, out_pc1 = 0x100, out_pc2 = 0x104, count = 2.
2. Push pair with in_hit1 = 1, in_pred1 = 1, pc1 = 0x200 → count increments by 1, out_valid2 = 0, F2 never appears.
3. Fill to count = 6 (DEPTH = 8) with deq_cnt = 0 → in_ready = 1; push one more pair → count = 8, in_ready = 0; further in_valid is ignored.
4. Hold count = 1 and apply deq_cnt = 2 → count = 0 next cycle; head advances by 1 only; no underflow.
5. count = 4, same cycle in_valid pair and deq_cnt = 2, flush = 1 → next cycle count = 0, in_ready = 1, out_valid1 = 0.
6. Run 20 pairs with deq_cnt = 2 every cycle → pointers wrap, PCs emerge in order 0x100, 0x104, … with none lost or duplicated.
